// File: rtl/gcd_test_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gcd_test_pkg
// Brief    : Shared constants, vector tables and state type for the GCD sink.
// Revision : 1.0
// ============================================================================
package gcd_test_pkg;

    localparam int GCD_TEST_NMSGS_MAX = 8;

    localparam logic [15:0] SRC_A [GCD_TEST_NMSGS_MAX] =
        '{16'd27, 16'd21, 16'd25, 16'd19, 16'd40, 16'd250, 16'd5, 16'd0};
    localparam logic [15:0] SRC_B [GCD_TEST_NMSGS_MAX] =
        '{16'd15, 16'd49, 16'd30, 16'd27, 16'd40, 16'd190, 16'd250, 16'd7};
    localparam logic [15:0] EXPECTED [GCD_TEST_NMSGS_MAX] =
        '{16'd3, 16'd7, 16'd5, 16'd1, 16'd40, 16'd10, 16'd5, 16'd7};

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } sink_state_e;

    function automatic logic [15:0] expected_at(input logic [2:0] idx);
        return EXPECTED[idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/gcd_test_sink_if.sv
`default_nettype none
// ============================================================================
// Module   : gcd_test_sink_if
// Brief    : Response val/rdy/msg channel between the GCD unit and its sink.
// Revision : 1.0
// ============================================================================
interface gcd_test_sink_if #(
    parameter int NBITS = 16
) ();
    logic             resp_val;
    logic             resp_rdy;
    logic [NBITS-1:0] resp_msg;

    modport master (output resp_val, output resp_msg, input resp_rdy);
    modport slave  (input resp_val, input resp_msg, output resp_rdy);
endinterface
`default_nettype wire

// File: rtl/gcd_test_sink_lfsr8.sv
`default_nettype none
// ============================================================================
// Module   : lfsr8
// Brief    : 8-bit Fibonacci LFSR, shifts left with XOR feedback into bit 0.
// Revision : 1.0
// ============================================================================
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5,
    parameter logic [7:0] TAPS = 8'hB8
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       en,
    output logic [7:0]      out
);
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & TAPS)};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out = lfsr_q;
endmodule
`default_nettype wire

// File: rtl/gcd_test_sink.sv
`default_nettype none
// ============================================================================
// Module   : gcd_test_sink
// Brief    : In-order response checker with pseudo-random backpressure.
// Revision : 1.0
// ============================================================================
module gcd_test_sink
    import gcd_test_pkg::*;
#(
    parameter int         NBITS     = 16,
    parameter int         NMSGS     = 8,
    parameter bit         STALL_EN  = 1'b1,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  wire logic       clk,
    input  wire logic       reset,
    gcd_test_sink_if.slave  resp,
    output logic            sink_done,
    output logic            err,
    output logic [7:0]      err_count,
    output logic [2:0]      first_err_idx,
    output logic            extra_msg
);
    localparam logic [2:0] C_LAST_IDX = 3'(NMSGS - 1);
    // x^8 + x^6 + x^5 + x^4 + 1 maps onto state bits 7,5,4,3
    localparam logic [7:0] C_TAPS     = 8'hB8;

    sink_state_e state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        sink_done_q, sink_done_d;
    logic        err_q, err_d;
    logic [7:0]  err_count_q, err_count_d;
    logic [2:0]  first_err_idx_q, first_err_idx_d;
    logic        extra_msg_q, extra_msg_d;

    logic [7:0]       w_lfsr;
    logic             w_lfsr_en;
    logic             w_stall;
    logic             w_rdy;
    logic             w_xfer;
    logic             w_mismatch;
    logic [15:0]      w_exp_raw;
    logic [NBITS-1:0] w_exp;
    logic             w_unused_lfsr;

    assign w_lfsr_en = (state_q == ST_RUN);

    lfsr8 #(
        .SEED (LFSR_SEED),
        .TAPS (C_TAPS)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (w_lfsr_en),
        .out   (w_lfsr)
    );

    assign w_unused_lfsr = &{1'b0, w_lfsr[7:2]};

    // Ready depends only on registered state, never on resp_val
    assign w_stall    = STALL_EN && (w_lfsr[1:0] == 2'b00);
    assign w_rdy      = !reset && (state_q == ST_RUN) && !w_stall;
    assign w_xfer     = resp.resp_val && w_rdy;
    assign w_exp_raw  = expected_at(idx_q);
    assign w_exp      = NBITS'(w_exp_raw);
    assign w_mismatch = (resp.resp_msg != w_exp);

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        sink_done_d     = sink_done_q;
        err_d           = err_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;
        extra_msg_d     = extra_msg_q;

        case (state_q)
            ST_RUN: begin
                if (w_xfer) begin
                    if (w_mismatch) begin
                        err_d = 1'b1;
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                        if (!err_q) begin
                            first_err_idx_d = idx_q;
                        end
                    end
                    idx_d = idx_q + 3'd1;
                    if (idx_q == C_LAST_IDX) begin
                        state_d     = ST_DONE;
                        sink_done_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (resp.resp_val) begin
                    extra_msg_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_RUN;
            idx_q           <= 3'd0;
            sink_done_q     <= 1'b0;
            err_q           <= 1'b0;
            err_count_q     <= 8'd0;
            first_err_idx_q <= 3'd0;
            extra_msg_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            sink_done_q     <= sink_done_d;
            err_q           <= err_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            extra_msg_q     <= extra_msg_d;
        end
    end

    assign resp.resp_rdy = w_rdy;
    assign sink_done     = sink_done_q;
    assign err           = err_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;
    assign extra_msg     = extra_msg_q;
endmodule
`default_nettype wire

// File: tb/tb_gcd_test_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_test_sink
// Brief    : Three sink instances (no stall / LFSR stall / single message)
//            checked every cycle against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_gcd_test_sink;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst;
    logic [2:0]  val;
    logic [15:0] msg [3];

    int n_err    = 0;
    int n_checks = 0;

    gcd_test_sink_if #(.NBITS(16)) bus0 ();
    gcd_test_sink_if #(.NBITS(16)) bus1 ();
    gcd_test_sink_if #(.NBITS(16)) bus2 ();

    assign bus0.resp_val = val[0];
    assign bus1.resp_val = val[1];
    assign bus2.resp_val = val[2];
    assign bus0.resp_msg = msg[0];
    assign bus1.resp_msg = msg[1];
    assign bus2.resp_msg = msg[2];

    wire [2:0] rdy;
    assign rdy = {bus2.resp_rdy, bus1.resp_rdy, bus0.resp_rdy};

    wire [2:0] done, errw, extra;
    wire [7:0] cnt0, cnt1, cnt2;
    wire [2:0] fi0, fi1, fi2;

    gcd_test_sink #(.NBITS(16), .NMSGS(8), .STALL_EN(1'b0), .LFSR_SEED(8'hA5)) dut0 (
        .clk(clk), .reset(rst[0]), .resp(bus0.slave), .sink_done(done[0]), .err(errw[0]),
        .err_count(cnt0), .first_err_idx(fi0), .extra_msg(extra[0]));
    gcd_test_sink #(.NBITS(16), .NMSGS(8), .STALL_EN(1'b1), .LFSR_SEED(8'hA5)) dut1 (
        .clk(clk), .reset(rst[1]), .resp(bus1.slave), .sink_done(done[1]), .err(errw[1]),
        .err_count(cnt1), .first_err_idx(fi1), .extra_msg(extra[1]));
    gcd_test_sink #(.NBITS(16), .NMSGS(1), .STALL_EN(1'b0), .LFSR_SEED(8'hA5)) dut2 (
        .clk(clk), .reset(rst[2]), .resp(bus2.slave), .sink_done(done[2]), .err(errw[2]),
        .err_count(cnt2), .first_err_idx(fi2), .extra_msg(extra[2]));

    // ---------------- behavioural model ----------------
    int  m_nmsgs    [3] = '{8, 8, 1};
    bit  m_stall_en [3] = '{1'b0, 1'b1, 1'b0};
    int  src_a      [8] = '{27, 21, 25, 19, 40, 250, 5, 0};
    int  src_b      [8] = '{15, 49, 30, 27, 40, 190, 250, 7};
    int  exp_tbl    [8];

    logic [7:0] m_lfsr  [3];
    int         m_idx   [3];
    int         m_cnt   [3];
    int         m_first [3];
    bit         m_done  [3];
    bit         m_err   [3];
    bit         m_extra [3];

    function automatic int gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = b;
            b = a % b;
            a = t;
        end
        return a;
    endfunction

    function automatic bit m_rdy(input int k);
        if (rst[k] || m_done[k]) return 1'b0;
        if (m_stall_en[k] && (m_lfsr[k] % 4 == 0)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset(input int k);
        m_lfsr[k]  = 8'hA5;
        m_idx[k]   = 0;
        m_cnt[k]   = 0;
        m_first[k] = 0;
        m_done[k]  = 1'b0;
        m_err[k]   = 1'b0;
        m_extra[k] = 1'b0;
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst[k]) begin
                if (m_done[k]) begin
                    if (val[k]) m_extra[k] = 1'b1;
                end else begin
                    if (val[k] && m_rdy(k)) begin
                        if (int'(msg[k]) != exp_tbl[m_idx[k]]) begin
                            if (!m_err[k]) m_first[k] = m_idx[k];
                            m_err[k] = 1'b1;
                            if (m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
                        end
                        m_idx[k] = m_idx[k] + 1;
                        if (m_idx[k] == m_nmsgs[k]) m_done[k] = 1'b1;
                    end
                    // polynomial x^8+x^6+x^5+x^4+1
                    m_lfsr[k] = {m_lfsr[k][6:0],
                                 m_lfsr[k][7] ^ m_lfsr[k][5] ^ m_lfsr[k][4] ^ m_lfsr[k][3]};
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] get_cnt(input int k);
        return (k == 0) ? cnt0 : (k == 1) ? cnt1 : cnt2;
    endfunction

    function automatic logic [2:0] get_fi(input int k);
        return (k == 0) ? fi0 : (k == 1) ? fi1 : fi2;
    endfunction

    // Compare every DUT against the model each cycle
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("dut%0d.resp_rdy", k),      32'(rdy[k]),       32'(m_rdy(k)));
            chk($sformatf("dut%0d.sink_done", k),     32'(done[k]),      32'(m_done[k]));
            chk($sformatf("dut%0d.err", k),           32'(errw[k]),      32'(m_err[k]));
            chk($sformatf("dut%0d.err_count", k),     32'(get_cnt(k)),   32'(m_cnt[k]));
            chk($sformatf("dut%0d.first_err_idx", k), 32'(get_fi(k)),    32'(m_first[k]));
            chk($sformatf("dut%0d.extra_msg", k),     32'(extra[k]),     32'(m_extra[k]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int k, input logic [15:0] m);
        int waited;
        waited = 0;
        val[k] = 1'b1;
        msg[k] = m;
        while (rdy[k] !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (waited >= 50) begin
            n_err++;
            $display("FAIL send_timeout dut%0d: rdy=%b after %0d cycles, required 1", k, rdy[k], waited);
        end
        @(negedge clk);
    endtask

    task automatic send_stream(input int k, input int n, input bit corrupt);
        logic [15:0] m;
        for (int i = 0; i < n; i++) begin
            m = 16'(exp_tbl[i]);
            if (corrupt && i == 2) m = 16'd6;
            if (corrupt && i == 5) m = 16'd11;
            send(k, m);
        end
        val[k] = 1'b0;
    endtask

    task automatic pulse_reset(input int k);
        #2 rst[k] = 1'b1;
        model_reset(k);
        @(negedge clk);
        #2 rst[k] = 1'b0;
        @(negedge clk);
    endtask

    bit pin_rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        for (int i = 0; i < 8; i++) exp_tbl[i] = gcd(src_a[i], src_b[i]);
        rst = 3'b111;
        val = 3'b000;
        for (int k = 0; k < 3; k++) begin
            msg[k] = 16'd0;
            model_reset(k);
        end
        repeat (3) @(negedge clk);
        chk("reset_rdy", 32'(rdy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        #2 rst = 3'b000;

        // LFSR from A5: A5,4A,95,2A,54 -> first stall on fifth cycle
        #1 chk("pin_rdy0", 32'(rdy[1]), 32'(pin_rdy[0]));
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("pin_rdy%0d", i), 32'(rdy[1]), 32'(pin_rdy[i]));
        end
        @(negedge clk);

        // No-stall back-to-back stream
        send_stream(0, 8, 1'b0);
        chk("t1_done", 32'(done[0]), 32'd1);
        chk("t1_err", 32'(errw[0]), 32'd0);
        chk("t1_cnt", 32'(cnt0), 32'd0);
        chk("t1_rdy_after", 32'(rdy[0]), 32'd0);

        // Stalled stream
        send_stream(1, 8, 1'b0);
        chk("t2_done", 32'(done[1]), 32'd1);
        chk("t2_err", 32'(errw[1]), 32'd0);

        // Extra message after done
        val[1] = 1'b1;
        msg[1] = 16'd1;
        repeat (3) begin
            @(negedge clk);
            chk("t4_rdy", 32'(rdy[1]), 32'd0);
        end
        val[1] = 1'b0;
        chk("t4_extra", 32'(extra[1]), 32'd1);
        chk("t4_cnt", 32'(cnt1), 32'd0);

        // Reset mid-stream after four transfers, one of them bad
        pulse_reset(1);
        send_stream(1, 4, 1'b1);
        chk("t5_pre_err", 32'(errw[1]), 32'd1);
        chk("t5_pre_first", 32'(fi1), 32'd2);
        #2 rst[1] = 1'b1;
        model_reset(1);
        #1;
        chk("t5_async_err", 32'(errw[1]), 32'd0);
        chk("t5_async_cnt", 32'(cnt1), 32'd0);
        chk("t5_async_first", 32'(fi1), 32'd0);
        chk("t5_async_rdy", 32'(rdy[1]), 32'd0);
        @(negedge clk);
        #2 rst[1] = 1'b0;
        @(negedge clk);
        send_stream(1, 8, 1'b0);
        chk("t5_done", 32'(done[1]), 32'd1);
        chk("t5_err", 32'(errw[1]), 32'd0);

        // Corrupted stream: msg2=6, msg5=11
        pulse_reset(1);
        send_stream(1, 8, 1'b1);
        chk("t3_done", 32'(done[1]), 32'd1);
        chk("t3_err", 32'(errw[1]), 32'd1);
        chk("t3_cnt", 32'(cnt1), 32'd2);
        chk("t3_first", 32'(fi1), 32'd2);

        // Single-message instance
        send(2, 16'd3);
        val[2] = 1'b0;
        chk("t6_done", 32'(done[2]), 32'd1);
        chk("t6_err", 32'(errw[2]), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("t6_rdy", 32'(rdy[2]), 32'd0);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/gcd_test_sink.md
Name: gcd_test_sink

Overview:
- Self-checking response sink for the GCD test harness. Sits directly downstream of the GCD unit inside GcdTop.
- Consumes resp val/rdy/msg, compares each message in order against a built-in expected-result table, and applies pseudo-random backpressure.
- Raises sink_done once all expected messages have arrived. Exposes error status for the testbench to poll.

Parameters:
- NBITS, 16, response message width.
- NMSGS, 8, number of responses expected; legal range 1..8 (table depth).
- STALL_EN, 1, 1 = LFSR-driven backpressure enabled; 0 = resp_rdy held high in RUN.
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock; the block has one clock.
- reset  in  1  asynchronous, active-high reset.
- resp_val  in  1  response valid from GCD.
- resp_rdy  out  1  sink ready.
- resp_msg  in  NBITS  GCD result.
- sink_done  out  1  all NMSGS responses received.
- err  out  1  sticky; at least one mismatch.
- err_count  out  8  number of mismatches, saturating at 255.
- first_err_idx  out  3  index of the first mismatching message.
- extra_msg  out  1  sticky; resp_val seen high while in DONE.

Behaviour:
- Reset (async assert, sync to clk on release; outputs take reset values immediately):
  - state=RUN, idx=0, lfsr=LFSR_SEED.
  - sink_done=0, err=0, err_count=0, first_err_idx=0, extra_msg=0.
  - resp_rdy=0 while reset is high.
- States: RUN, DONE.
- RUN:
  - stall = STALL_EN && (lfsr[1:0]==2'b00), i.e. ~25% stall.
  - resp_rdy = !stall (combinational from registered lfsr).
  - LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every cycle in RUN regardless of transfers; frozen in DONE.
- Transfer = resp_val && resp_rdy, sampled at posedge clk. On each transfer:
  - Compare resp_msg to EXPECTED[idx] (zero-extended/truncated to NBITS).
  - On mismatch: err<=1; err_count<=sat(err_count+1); if err was 0, first_err_idx<=idx.
  - idx<=idx+1.
  - If idx==NMSGS-1: state<=DONE and sink_done<=1 in the same edge, so sink_done is visible the cycle after the last transfer.
- resp_val high with resp_rdy low: no transfer, no state change. resp_msg is ignored.
- DONE:
  - resp_rdy=0; sink_done stays 1 until reset.
  - Any cycle with resp_val=1 sets extra_msg.
  - idx and error counters frozen.
- Handshake: the sink never depends on resp_val to drive resp_rdy (no combinational loop). A response held valid across stall cycles is consumed exactly once.
- Reset mid-stream: all progress discarded. After release, checking restarts at idx 0; the producer must also be reset.
- Mismatches never stop the sink. Checking continues to NMSGS.

Decomposition:
- Package gcd_test_pkg holds:
  - GCD_TEST_NMSGS_MAX=8.
  - Source vector table SRC_A/SRC_B: (27,15), (21,49), (25,30), (19,27), (40,40), (250,190), (5,250), (0,7).
  - EXPECTED table: 3, 7, 5, 1, 40, 10, 5, 7.
  - State enum {RUN, DONE}.
- One sub-module, lfsr8: parameters SEED, TAPS; ports clk, reset, en, out[7:0].

Test Plan:
- STALL_EN=0, producer presents all 8 expected values back-to-back with resp_val=1 → resp_rdy=1 every cycle; sink_done=1 one cycle after 8th transfer; err=0, err_count=0.
- STALL_EN=1, seed 8'hA5, correct stream → resp_rdy low on cycles where lfsr[1:0]==0; each msg consumed once; sink_done after 8 transfers; err=0.
- Correct stream except msg 2 = 6 and msg 5 = 11 → err=1, err_count=2, first_err_idx=2, sink_done=1.
- After sink_done, producer asserts resp_val with msg 3 → resp_rdy stays 0, extra_msg=1, err_count unchanged.
- Reset asserted mid-cycle after 4 transfers, then released and full stream replayed → outputs clear asynchronously; idx restarts at 0; sink_done after 8 new transfers, err=0.
- NMSGS=1, single response 3 → sink_done=1 one cycle after first transfer; resp_rdy=0 thereafter.
